lvds_tx_train_gen: RTL

// Transmit-side word generator that feeds the 10-bit LVDS serializer (tx_in of the ALTLVDS_TX megafunction).

---
 rtl/lvds_tx_train_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lvds_tx_train_gen.sv
// Word generator for a 10-bit LVDS serializer: a comma training burst lets the
// far end bit-slip-align, then repeat-count payload frames follow.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ALIGN_WORD on the link, flags low, waiting for lock & start
// S_TRAIN | TRAIN_LEN words of ALIGN_WORD, train_active high
// S_DATA  | {2'b10, payload}, each byte held REPEAT_CNT words
module lvds_tx_train_gen #(
  parameter logic [9:0] ALIGN_WORD = 10'h0FA,
  parameter int         TRAIN_LEN  = 256,
  parameter int         REPEAT_CNT = 125,
  parameter int         NUM_VALUES = 256,
  parameter bit         CONTINUOUS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_locked,
  input  logic       start,
  input  logic       retrain,
  output logic [9:0] tx_data,
  output logic [7:0] payload,
  output logic       train_active,
  output logic       data_active,
  output logic       frame_done
);

  localparam int TW = (TRAIN_LEN  > 1) ? $clog2(TRAIN_LEN)  : 1;
  localparam int RW = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
  localparam int PW = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;

  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_LEN - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CNT - 1);
  localparam logic [PW-1:0] PAY_LAST   = PW'(NUM_VALUES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [PW-1:0] pay_q, pay_d;

  logic [9:0] tx_data_q, tx_data_d;
  logic [7:0] payload_q, payload_d;
  logic       train_q, train_d;
  logic       data_q, data_d;
  logic       done_q, done_d;
  logic [7:0] pay8;

  // State, counters and output words all advance together on the word clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rep_q     <= '0;
      pay_q     <= '0;
      tx_data_q <= ALIGN_WORD;
      payload_q <= '0;
      train_q   <= 1'b0;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      pay_q     <= pay_d;
      tx_data_q <= tx_data_d;
      payload_q <= payload_d;
      train_q   <= train_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  // Next state and counters; the _q registers describe the word now on tx_data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    pay_d   = pay_q;
    if (!tx_locked) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rep_d   = '0;
      pay_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          rep_d = '0;
          pay_d = '0;
          if (start) state_d = S_TRAIN;
        end
        S_TRAIN: begin
          if (retrain) begin
            cnt_d = '0;
          end else if (cnt_q == TRAIN_LAST) begin
            state_d = S_DATA;
            cnt_d   = '0;
            rep_d   = '0;
            pay_d   = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (retrain) begin
            state_d = S_TRAIN;
            cnt_d   = '0;
            rep_d   = '0;
            pay_d   = '0;
          end else if ((pay_q == PAY_LAST) && (rep_q == REP_LAST)) begin
            // Frame end: payload wraps here and nowhere else.
            rep_d = '0;
            pay_d = '0;
            if (!(CONTINUOUS && start)) state_d = S_IDLE;
          end else if (rep_q == REP_LAST) begin
            rep_d = '0;
            pay_d = pay_q + PW'(1);
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rep_d   = '0;
          pay_d   = '0;
        end
      endcase
    end
  end

  // Output words are decoded from the next state so they register alongside it.
  always_comb begin
    tx_data_d = ALIGN_WORD;
    payload_d = '0;
    train_d   = 1'b0;
    data_d    = 1'b0;
    done_d    = 1'b0;
    pay8      = '0;
    pay8[PW-1:0] = pay_d;
    case (state_d)
      S_TRAIN: train_d = 1'b1;
      S_DATA: begin
        payload_d = pay8;
        tx_data_d = {2'b10, pay8};
        data_d    = 1'b1;
        done_d    = (pay_d == PAY_LAST) && (rep_d == REP_LAST);
      end
      default: ;
    endcase
  end

  assign tx_data      = tx_data_q;
  assign payload      = payload_q;
  assign train_active = train_q;
  assign data_active  = data_q;
  assign frame_done   = done_q;

endmodule
